rsa_modexp_core: RTL and testbench
==================================

Name: rsa_modexp_core

Overview:
Parametrised successor of the team's 256-bit RSA register block. It computes result = M^E mod N using bit-serial Montgomery multiplication, with a configurable operand width W and exponent width EW. Operands are loaded and the result is read through the existing byte-wide reg_sel/addr register port. The block sits between the bus-side byte interface and the crypto top level, and reports progress with ready/done/err.

Parameters:
W, 256, operand/modulus width in bits; multiple of 8, at least 16
EW, 256, exponent width in bits; multiple of 8, at most W
AW, $clog2(W/8), byte address width (derived)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
we  in  1  active-low byte write strobe
oe  in  1  active-low byte read strobe
start  in  1  active-high; sampled only in IDLE
reg_sel  in  2  0=result (RO), 1=message M, 2=exponent E, 3=modulus N
addr  in  AW  byte index; byte k = bits [8k+7:8k]
data_i  in  8  write data
data_o  out  8  registered read data
ready  out  1  high in IDLE
done  out  1  one-cycle completion pulse
err  out  1  sticky error flag, cleared by the next accepted start

Behaviour:
- Reset (async, reset=0):
  - FSM goes to IDLE.
  - M, E, N and result clear to 0.
  - data_o=0, ready=1, done=0, err=0.
  - Reset asserted mid-operation aborts immediately. No partial result is kept.
- Writes (we=0 at a clk edge, state IDLE):
  - The addressed byte of the register selected by reg_sel is loaded.
  - E bytes with addr>=EW/8 are ignored.
  - Writes with reg_sel=0, writes outside IDLE, and writes with addr>=W/8 are ignored.
  - If we=0 and oe=0 together, the write takes effect and data_o still updates.
- Reads (oe=0 at a clk edge):
  - data_o <= selected byte of the register chosen by reg_sel, so read latency is 1 cycle.
  - reg_sel 1-3 read back their operands.
  - addr>=W/8 returns 0.
  - Reads are allowed in any state. data_o holds its value when oe=1.
- FSM states: IDLE, PRE, TOMONT, EXP, FROMMONT, DONE.
  - IDLE -> PRE: start=1 and N[0]=1. Clears err and drops ready.
  - IDLE, start=1 and N[0]=0: no computation; next cycle err=1, done pulses, result=0, ready stays 1.
  - PRE, 2W cycles: x starts at 1; each cycle x = 2x, then subtract N if x>=N. Ends with R2 = 2^(2W) mod N. Datapath is W+1 bits.
  - TOMONT, W+1 cycles: two Montgomery multipliers run concurrently, T = MM(M,R2) and U = MM(1,R2).
  - EXP, EW*(W+1) cycles: for bit k = 0..EW-1, LSB first:
    - U = MM(U,T) if E[k]=1, otherwise U holds;
    - T = MM(T,T) in parallel.
  - FROMMONT, W+1 cycles: result = MM(U,1).
  - DONE, 1 cycle: done=1, result register updated, then -> IDLE with ready=1.
- Montgomery product MM(A,B), W+1 cycles:
  - Accumulator u is W+2 bits and starts at 0.
  - For i = 0..W-1: t = u + A[i]*B, then u = (t + t[0]*N) >> 1.
  - Final cycle: if u>=N, u -= N.
- Latency:
  - Fixed and data-independent: L = 2W + (EW+2)(W+1) cycles from the start-sampling edge to the done pulse.
  - No leading-zero skipping.
- Boundaries:
  - start outside IDLE is ignored.
  - E=0 gives result = 1 mod N.
  - M>=N is permitted; the result equals (M mod N)^E mod N.
  - N=1 is odd and legal; the result is 0.
  - The result register holds until the next DONE or reset.

Test Plan:
- W=16, EW=16: write M=0x0004, E=0x000D, N=0x01F1, pulse start -> ready=0, done pulses after 338 cycles, result reads back 0x01BD (445) as addr0=0xBD, addr1=0x01.
- Same N, E=0x0000, M=0x1234 -> result 0x0001 after 338 cycles. Then E=0x0001, M=0x01F0 -> result 0x01F0.
- N=0x01F0 (even), start -> next cycle err=1, done=1, ready stays 1, result=0. A following valid start clears err.
- Start a valid run, write M=0xFFFF mid-run and pulse start again -> both ignored, result 0x01BD, done after exactly 338 cycles. Then assert reset mid-run -> ready=1, done=0, all registers read back 0.
- Readback check: write bytes to reg_sel 1/2/3, read each with oe=0 -> data_o matches one cycle later. addr>=2 returns 0x00.
- Default W=EW=256: random odd N, M<N, E checked against a golden model for 20 vectors. Latency 2*256 + 258*257 = 66818 cycles each.

Source files
------------

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core
//   Computes result = M^E mod N with bit-serial Montgomery multiplication.
//   Operands are loaded and the result is read through a byte-wide
//   reg_sel/addr register port. Latency is fixed:
//   2W + (EW+2)(W+1) cycles from the start-sampling edge to done.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset
//   we       active-low byte write strobe (honoured only in IDLE)
//   oe       active-low byte read strobe (any state)
//   start    active-high start, sampled only in IDLE
//   reg_sel  0=result (RO), 1=M, 2=E, 3=N
//   addr     byte index, byte k = bits [8k+7:8k]
//   data_i   write data
//   data_o   registered read data (1-cycle latency, holds when oe=1)
//   ready    high in IDLE
//   done     one-cycle completion pulse
//   err      sticky error (even modulus), cleared by the next accepted start
module rsa_modexp_core #(
  parameter int W  = 256,
  parameter int EW = 256,
  parameter int AW = $clog2(W/8)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          oe,
  input  logic          start,
  input  logic [1:0]    reg_sel,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    data_i,
  output logic [7:0]    data_o,
  output logic          ready,
  output logic          done,
  output logic          err
);

  localparam int CW = $clog2(2*W) + 1;
  localparam int IW = $clog2(W);
  localparam int KW = $clog2(EW);

  typedef enum logic [2:0] {IDLE, PRE, TOMONT, EXP, FROMMONT, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [KW-1:0] kbit;

  logic [W-1:0]  m_reg, n_reg, res_reg;
  logic [EW-1:0] e_reg;

  // Montgomery-domain working values: r2 = 2^(2W) mod N, t = base, u = running product
  logic [W-1:0]  r2_reg, t_reg, u_reg;
  logic [W+1:0]  acc0, acc1;

  logic [W-1:0]  a0, b0, a1, b1;
  logic [W+1:0]  step0, step1;
  logic [IW-1:0] bidx;
  logic          mm_last, pre_last, accept, reject;
  logic          addr_ok, e_addr_ok;
  logic [7:0]    rd_byte;

  // One Montgomery iteration: add A[i]*B, make even by adding N, halve.
  function automatic logic [W+1:0] mm_step(input logic [W+1:0] u, input logic abit,
                                           input logic [W-1:0] b, input logic [W-1:0] n);
    logic [W+2:0] t;
    t = {1'b0, u} + (abit ? {3'b000, b} : {(W+3){1'b0}});
    if (t[0])
      t = t + {3'b000, n};
    return t[W+2:1];
  endfunction

  // Final conditional subtraction bringing the product below N.
  function automatic logic [W-1:0] mm_final(input logic [W+1:0] u, input logic [W-1:0] n);
    return W'((u >= {2'b00, n}) ? (u - {2'b00, n}) : u);
  endfunction

  // Modular doubling on a W+1 bit datapath; x < N on entry.
  function automatic logic [W-1:0] mod_dbl(input logic [W-1:0] x, input logic [W-1:0] n);
    logic [W:0] d;
    d = {x, 1'b0};
    return W'((d >= {1'b0, n}) ? (d - {1'b0, n}) : d);
  endfunction

  function automatic logic [7:0] get_byte(input logic [W-1:0] v, input logic [AW-1:0] a);
    logic [W-1:0] s;
    s = v >> {a, 3'b000};
    return s[7:0];
  endfunction

  assign ready     = (state == IDLE);
  assign mm_last   = (cnt == CW'(W));
  assign pre_last  = (cnt == CW'(2*W-1));
  assign accept    = (state == IDLE) && start && n_reg[0];
  assign reject    = (state == IDLE) && start && !n_reg[0];
  assign addr_ok   = ({1'b0, addr} < (AW+1)'(W/8));
  assign e_addr_ok = ({1'b0, addr} < (AW+1)'(EW/8));
  assign bidx      = cnt[IW-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept)   state_nxt = PRE;
      PRE:      if (pre_last) state_nxt = TOMONT;
      TOMONT:   if (mm_last)  state_nxt = EXP;
      EXP:      if (mm_last && (kbit == KW'(EW-1))) state_nxt = FROMMONT;
      FROMMONT: if (mm_last)  state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Operand routing: multiplier 0 builds T, multiplier 1 builds U / the result.
  always_comb begin
    a0 = t_reg;
    b0 = t_reg;
    a1 = u_reg;
    b1 = t_reg;
    case (state)
      TOMONT: begin
        a0 = m_reg;
        b0 = r2_reg;
        a1 = W'(1);
        b1 = r2_reg;
      end
      FROMMONT: begin
        a1 = u_reg;
        b1 = W'(1);
      end
      default: ;
    endcase
  end

  assign step0 = mm_step(acc0, a0[bidx], b0, n_reg);
  assign step1 = mm_step(acc1, a1[bidx], b1, n_reg);

  always_comb begin
    rd_byte = 8'h00;
    if (addr_ok) begin
      case (reg_sel)
        2'd0: rd_byte = get_byte(res_reg, addr);
        2'd1: rd_byte = get_byte(m_reg, addr);
        2'd2: if (e_addr_ok) rd_byte = get_byte(W'(e_reg), addr);
        2'd3: rd_byte = get_byte(n_reg, addr);
        default: rd_byte = 8'h00;
      endcase
    end
  end

  // Control, operand registers and register port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      kbit    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      data_o  <= 8'h00;
      m_reg   <= '0;
      e_reg   <= '0;
      n_reg   <= '0;
      res_reg <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;

      case (state)
        PRE:                     cnt <= pre_last ? '0 : cnt + 1'b1;
        TOMONT, EXP, FROMMONT:   cnt <= mm_last  ? '0 : cnt + 1'b1;
        default:                 cnt <= '0;
      endcase

      if (state == IDLE)
        kbit <= '0;
      else if ((state == EXP) && mm_last)
        kbit <= (kbit == KW'(EW-1)) ? '0 : kbit + 1'b1;

      if (accept)
        err <= 1'b0;
      if (reject) begin
        err     <= 1'b1;
        done    <= 1'b1;
        res_reg <= '0;
      end
      if ((state == FROMMONT) && mm_last) begin
        res_reg <= mm_final(acc1, n_reg);
        done    <= 1'b1;
      end

      if (!we && (state == IDLE) && addr_ok) begin
        for (int k = 0; k < W/8; k++) begin
          if (addr == AW'(k)) begin
            if (reg_sel == 2'd1) m_reg[8*k +: 8] <= data_i;
            if (reg_sel == 2'd3) n_reg[8*k +: 8] <= data_i;
          end
        end
        for (int k = 0; k < EW/8; k++) begin
          if ((addr == AW'(k)) && (reg_sel == 2'd2))
            e_reg[8*k +: 8] <= data_i;
        end
      end

      if (!oe)
        data_o <= rd_byte;
    end
  end

  // Arithmetic datapath: R2 precompute, then the two concurrent multipliers
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        r2_reg <= W'(1);
        acc0   <= '0;
        acc1   <= '0;
      end
      PRE: r2_reg <= mod_dbl(r2_reg, n_reg);
      TOMONT, EXP, FROMMONT: begin
        if (mm_last) begin
          acc0 <= '0;
          acc1 <= '0;
          if (state == TOMONT) begin
            t_reg <= mm_final(acc0, n_reg);
            u_reg <= mm_final(acc1, n_reg);
          end
          if (state == EXP) begin
            t_reg <= mm_final(acc0, n_reg);
            if (e_reg[kbit])
              u_reg <= mm_final(acc1, n_reg);
          end
        end else begin
          acc0 <= step0;
          acc1 <= step1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rsa_modexp_core.sv
module tb_rsa_modexp_core;

  localparam int W   = 16;
  localparam int EW  = 16;
  localparam int AW  = 1;
  localparam int LAT = 2*W + (EW+2)*(W+1);

  logic          clk;
  logic          rst_n;
  logic          we, oe, start;
  logic [1:0]    reg_sel;
  logic [AW-1:0] addr;
  logic [7:0]    data_i;
  logic [7:0]    data_o;
  logic          ready, done, err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;

  rsa_modexp_core #(.W(W), .EW(EW)) dut (
    .clk(clk), .reset(rst_n), .we(we), .oe(oe), .start(start),
    .reg_sel(reg_sel), .addr(addr), .data_i(data_i), .data_o(data_o),
    .ready(ready), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference: square-and-multiply with plain integer arithmetic.
  function automatic logic [15:0] modexp_ref(input logic [15:0] m, input logic [15:0] e,
                                             input logic [15:0] n);
    longint r, b;
    r = 64'd1 % longint'(n);
    b = longint'(m) % longint'(n);
    for (int i = 0; i < EW; i++) begin
      if (e[i]) r = (r * b) % longint'(n);
      b = (b * b) % longint'(n);
    end
    return 16'(r);
  endfunction

  function automatic logic [7:0] sel_byte(input logic [15:0] v, input logic a);
    return a ? v[15:8] : v[7:0];
  endfunction

  // Transaction-level model of the block, checked every cycle.
  logic [15:0] m_m, m_e, m_n, m_res, m_pend;
  bit          m_busy;
  int          m_cnt;
  logic        m_done, m_err, m_ready;
  logic [7:0]  m_dout;

  always @(posedge clk) begin : model_cmp
    bit idle;
    if (!rst_n) begin
      m_m = 0; m_e = 0; m_n = 0; m_res = 0; m_pend = 0;
      m_busy = 0; m_cnt = 0;
      m_done = 0; m_err = 0; m_ready = 1; m_dout = 0;
    end else begin
      idle   = !m_busy;
      m_done = 0;
      if (!oe) begin
        case (reg_sel)
          2'd0: m_dout = sel_byte(m_res, addr);
          2'd1: m_dout = sel_byte(m_m, addr);
          2'd2: m_dout = sel_byte(m_e, addr);
          default: m_dout = sel_byte(m_n, addr);
        endcase
      end
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == LAT) begin
          m_done = 1;
          m_res  = m_pend;
        end else if (m_cnt == LAT + 1) begin
          m_busy = 0;
        end
      end
      if (!we && idle) begin
        case (reg_sel)
          2'd1: if (addr) m_m[15:8] = data_i; else m_m[7:0] = data_i;
          2'd2: if (addr) m_e[15:8] = data_i; else m_e[7:0] = data_i;
          2'd3: if (addr) m_n[15:8] = data_i; else m_n[7:0] = data_i;
          default: ;
        endcase
      end
      if (idle && start) begin
        if (m_n[0]) begin
          m_busy = 1;
          m_cnt  = 0;
          m_err  = 0;
          m_pend = modexp_ref(m_m, m_e, m_n);
        end else begin
          m_err  = 1;
          m_done = 1;
          m_res  = 0;
        end
      end
      m_ready = !m_busy;
    end
    #1;
    chk("ready", 16'(ready), 16'(m_ready));
    chk("done", 16'(done), 16'(m_done));
    chk("err", 16'(err), 16'(m_err));
    chk("data_o", 16'(data_o), 16'(m_dout));
  end

  // Stimulus tasks: each starts and ends just after a falling edge.
  task automatic wr(input logic [1:0] s, input logic a, input logic [7:0] d);
    we = 1'b0; reg_sel = s; addr = a; data_i = d;
    @(negedge clk);
    we = 1'b1;
  endtask

  task automatic wr16(input logic [1:0] s, input logic [15:0] v);
    wr(s, 1'b0, v[7:0]);
    wr(s, 1'b1, v[15:8]);
  endtask

  task automatic rd(input logic [1:0] s, input logic a, output logic [7:0] d);
    oe = 1'b0; reg_sel = s; addr = a;
    @(posedge clk);
    #1 d = data_o;
    @(negedge clk);
    oe = 1'b1;
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] s, input logic [15:0] exp);
    logic [7:0] lo, hi;
    rd(s, 1'b0, lo);
    rd(s, 1'b1, hi);
    chk(nm, {hi, lo}, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: done not seen within %0d cycles", nm, LAT + 20);
    end else begin
      chk(nm, 16'(cyc - t0), 16'(LAT));
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] m, e, n, v;
    rst_n = 1'b0; we = 1'b1; oe = 1'b1; start = 1'b0;
    reg_sel = 2'd0; addr = '0; data_i = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    rd_chk("rst_res", 2'd0, 16'h0000);
    rd_chk("rst_n", 2'd3, 16'h0000);

    // 4^13 mod 497 = 445
    wr16(2'd3, 16'h01F1);
    wr16(2'd2, 16'h000D);
    wr16(2'd1, 16'h0004);
    pulse_start();
    chk("busy_ready", 16'(ready), 16'h0000);
    wait_done("lat_basic");
    rd_chk("res_basic", 2'd0, 16'h01BD);

    // E = 0 gives 1
    wr16(2'd2, 16'h0000);
    wr16(2'd1, 16'h1234);
    pulse_start();
    wait_done("lat_e0");
    rd_chk("res_e0", 2'd0, 16'h0001);

    // E = 1, M = N-1
    wr16(2'd2, 16'h0001);
    wr16(2'd1, 16'h01F0);
    pulse_start();
    wait_done("lat_e1");
    rd_chk("res_e1", 2'd0, 16'h01F0);

    // Even modulus
    wr16(2'd3, 16'h01F0);
    pulse_start();
    chk("even_done", 16'(done), 16'h0001);
    chk("even_err", 16'(err), 16'h0001);
    chk("even_ready", 16'(ready), 16'h0001);
    rd_chk("even_res", 2'd0, 16'h0000);
    chk("err_sticky", 16'(err), 16'h0001);

    // Valid start clears err; mid-run write and start are ignored
    wr16(2'd3, 16'h01F1);
    wr16(2'd2, 16'h000D);
    wr16(2'd1, 16'h0004);
    pulse_start();
    chk("err_clear", 16'(err), 16'h0000);
    repeat (40) @(negedge clk);
    wr16(2'd1, 16'hFFFF);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("lat_midrun");
    rd_chk("res_midrun", 2'd0, 16'h01BD);
    rd_chk("m_kept", 2'd1, 16'h0004);

    // Reset mid-run
    pulse_start();
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 16'(ready), 16'h0001);
    chk("arst_done", 16'(done), 16'h0000);
    chk("arst_dout", 16'(data_o), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("arst_res", 2'd0, 16'h0000);
    rd_chk("arst_m", 2'd1, 16'h0000);
    rd_chk("arst_e", 2'd2, 16'h0000);
    rd_chk("arst_n", 2'd3, 16'h0000);

    // Register readback; writes to the result register are ignored
    for (int s = 1; s <= 3; s++) begin
      v = 16'($urandom_range(0, 65535));
      wr16(2'(s), v);
      rd_chk("readback", 2'(s), v);
    end
    wr16(2'd0, 16'hA5A5);
    rd_chk("res_ro", 2'd0, 16'h0000);

    // Randomized vectors
    for (int k = 0; k < 30; k++) begin
      n = (k % 8 == 0) ? 16'h0001 : (16'($urandom_range(3, 65535)) | 16'h0001);
      m = 16'($urandom_range(0, 65535));
      e = (k % 7 == 3) ? 16'h0000 : 16'($urandom_range(0, 65535));
      wr16(2'd3, n);
      wr16(2'd2, e);
      wr16(2'd1, m);
      pulse_start();
      wait_done("lat_rand");
      rd_chk("res_rand", 2'd0, modexp_ref(m, e, n));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
